fetch_queue_unit: RTL
=====================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised instruction-fetch front end. Drives the synchronous instruction
//  memory (1-cycle read latency), buffers returned words with their PC in a
//  DEPTH-entry queue, and presents them to decode over a valid/ready handshake.
//  Branch redirect flushes queue and in-flight read; stop halts new fetches.
// PARAMETERS
//  PC_W      32   width of PC, redirect_pc, inst_pc; PC counts in words, +1 per fetch
//  ADDR_W    7    instruction-memory address width; IMaddra = fetch_pc[ADDR_W-1:0]
//  INST_W    32   instruction word width
//  DEPTH     4    queue entries; power of two, >= 2
//  RESET_PC  0    fetch_pc value after reset
// PORTS
//  clk          in   1       clock; all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  stop         in   1       1 = issue no new fetches (halt / load or divide stall)
//  redirect     in   1       1 = branch taken; flush and refetch from redirect_pc
//  redirect_pc  in   PC_W    branch target, sampled when redirect=1
//  inst_valid   out  1       queue head holds a valid instruction
//  inst_ready   in   1       decode accepts head this cycle
//  inst         out  INST_W  head instruction
//  inst_pc      out  PC_W    PC of head instruction
//  IMclka       out  1       = clk
//  IMena        out  1       memory read enable (= fetch issue this cycle)
//  IMaddra      out  ADDR_W  memory read address
//  IMdouta      in   INST_W  memory read data, valid the cycle after IMena=1
// BEHAVIOUR
//  Reset (rst_n=0, async): fetch_pc=RESET_PC, queue empty, in-flight flag 0;
//   inst_valid=0, inst=0, inst_pc=0, IMena=0. Reset mid-stream discards all state.
//  Issue: IMena = rst_n & !stop & !redirect & (count + inflight < DEPTH).
//   On issue: issue_pc<=fetch_pc, inflight<=1, fetch_pc<=fetch_pc+1 (mod 2^PC_W).
//  Response: cycle after issue, {IMdouta, issue_pc} pushed into queue tail unless
//   redirect=1 that cycle (dropped). inflight<=0 when no new issue.
//  Queue: FWFT; inst/inst_pc driven from head register storage, inst_valid=(count!=0).
//   Pop on inst_valid & inst_ready. Push+pop same cycle: count unchanged.
//   Issue gate counts in-flight word, so push never hits a full queue; no overflow.
//   Pop when empty ignored. Pointers wrap modulo DEPTH.
//  Throughput: 1 instruction/cycle when inst_ready=1 continuously.
//  Redirect (priority over stop and issue): at edge, count<=0, pointers reset,
//   inflight<=0, fetch_pc<=redirect_pc. A pop handshake in the redirect cycle
//   completes normally. Cycle N redirect -> N+1 IMena=1 addr=target ->
//   N+2 data returns -> N+3 inst_valid=1, inst_pc=target (3-cycle latency).
//   redirect held several cycles: each cycle reloads fetch_pc, no issue.
//  Stop: no issue while 1; in-flight word still pushed; queue drains to decode;
//   fetch_pc held. Stop and redirect together: redirect applied, issue waits for !stop.
//  inst/inst_pc hold last head value when queue empty (don't-care for decode).
// TESTING
//  1 Stream: RESET_PC=0, mem[a]=0x100+a, inst_ready=1 -> inst_valid from cycle 3
//    after reset release; inst_pc 0,1,2,... inst 0x100,0x101,... one per cycle.
//  2 Backpressure: inst_ready=0 -> exactly DEPTH=4 entries (pc 0..3), IMena low
//    thereafter; release -> pc 0..3 then 4.. in order, none lost or duplicated.
//  3 Redirect: with 3 queued, redirect=1 redirect_pc=0x40 -> inst_valid=0 next
//    cycle, in-flight word not delivered, inst_pc=0x40 three cycles after redirect.
//  4 Stop: stop=1 for 5 cycles mid-stream -> IMena=0, queued words still drain;
//    after release fetch resumes at next sequential pc, no gap.
//  5 Wrap: PC_W=8, RESET_PC=0xFE -> inst_pc 0xFE,0xFF,0x00; IMaddra 0x7E,0x7F,0x00.
//  6 Async reset mid-stream (queue full, inflight=1) -> outputs 0 immediately;
//    after release behaves as test 1, no stale word appears.

Source files
------------

// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bus: decode handshake, redirect/stop control and instruction-memory port.
// master = the fetch unit, slave = the surrounding core/memory.
interface fetch_queue_unit_if #(
    parameter int PC_W   = 32,
    parameter int ADDR_W = 7,
    parameter int INST_W = 32
);
    logic              stop;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              IMclka;
    logic              IMena;
    logic [ADDR_W-1:0] IMaddra;
    logic [INST_W-1:0] IMdouta;

    modport master (
        input  stop, redirect, redirect_pc, inst_ready, IMdouta,
        output inst_valid, inst, inst_pc, IMclka, IMena, IMaddra
    );

    modport slave (
        output stop, redirect, redirect_pc, inst_ready, IMdouta,
        input  inst_valid, inst, inst_pc, IMclka, IMena, IMaddra
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: issues reads to a 1-cycle synchronous memory and
// buffers returned words with their PC in a FWFT queue feeding decode.
module fetch_queue_unit #(
    parameter int              PC_W     = 32,
    parameter int              ADDR_W   = 7,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_queue_unit_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   r_fetch_pc;
    logic [PC_W-1:0]   r_issue_pc;
    logic              r_inflight;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [INST_W-1:0] r_inst_q [DEPTH];
    logic [PC_W-1:0]   r_pc_q   [DEPTH];

    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic [CNT_W:0]    w_occupancy;

    // The outstanding read reserves a slot, so a returning word always fits.
    assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue     = rst_n & ~bus.stop & ~bus.redirect
                         & (w_occupancy < (CNT_W+1)'(DEPTH));
    assign w_push      = r_inflight & ~bus.redirect;
    assign w_pop       = (r_count != '0) & bus.inst_ready;

    assign bus.IMclka     = clk;
    assign bus.IMena      = w_issue;
    assign bus.IMaddra    = r_fetch_pc[ADDR_W-1:0];
    assign bus.inst_valid = (r_count != '0);
    assign bus.inst       = r_inst_q[r_rd_ptr];
    assign bus.inst_pc    = r_pc_q[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_issue_pc <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (bus.redirect) begin
            r_fetch_pc <= bus.redirect_pc;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_issue_pc <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + PC_W'(1);
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_q[i] <= '0;
                r_pc_q[i]   <= '0;
            end
        end else if (w_push) begin
            r_inst_q[r_wr_ptr] <= bus.IMdouta;
            r_pc_q[r_wr_ptr]   <= r_issue_pc;
        end
    end
endmodule
